// File: rtl/req_queue4_pkg.sv
// req_queue4_pkg: shared definitions for the four-channel request buffer.
//   NUM_CH     - number of requester channels
//   src_t      - channel index carried with each popped entry
//   is_onehot4 - true when exactly one of four grant bits is set
package req_queue4_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] src_t;

  function automatic logic is_onehot4(input logic [3:0] g);
    return (g != 4'b0000) && ((g & (g - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// req_fifo: single-channel circular FIFO with an explicit occupancy count.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   push, push_data  - write request and data (ignored when full)
//   pop              - read request (ignored when empty)
//   head             - entry at the read pointer
//   count            - registered occupancy, 0..DEPTH
//   full, empty      - decoded from the registered count
module req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  // Full/empty come from the registered count, so a pop this cycle does
  // not make room for a push until the next cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/req_queue4.sv
// req_queue4: four-channel request buffer in front of a 4-way arbiter.
// Each channel owns a req_fifo; req[] reports non-empty channels, and a
// legal one-hot grant pops the granted head onto out_data/out_src with a
// one-cycle out_valid pulse. Illegal grants (multi-hot, or targeting an
// empty channel) pop nothing and pulse gnt_err.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   in_valid[3:0]            - per-channel push request (bit0 = a)
//   in_data_a..in_data_d     - push data per channel
//   in_ready[3:0]            - per-channel FIFO not full
//   req[3:0]                 - per-channel FIFO non-empty
//   gnt_a..gnt_d             - arbiter grants
//   out_valid, out_data, out_src - registered popped entry
//   gnt_err                  - registered illegal-grant pulse
// Optional (REQ_QUEUE4_LEVEL_EN defined):
//   level                    - all four registered counts, channel a lowest
//   ovf_sticky[3:0]          - set on push attempt while full, reset-only clear
module req_queue4
  import req_queue4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  input  logic [DATA_W-1:0] in_data_c,
  input  logic [DATA_W-1:0] in_data_d,
  output logic [3:0]        in_ready,
  output logic [3:0]        req,
  input  logic              gnt_a,
  input  logic              gnt_b,
  input  logic              gnt_c,
  input  logic              gnt_d,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output src_t              out_src,
  output logic              gnt_err
`ifdef REQ_QUEUE4_LEVEL_EN
  ,
  output logic [4*($clog2(DEPTH)+1)-1:0] level,
  output logic [3:0]        ovf_sticky
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_data [NUM_CH];
  logic [DATA_W-1:0] head    [NUM_CH];
  logic [CW-1:0]     count   [NUM_CH];
  logic [3:0]        full;
  logic [3:0]        empty;
  logic [3:0]        push;
  logic [3:0]        pop;
  logic [3:0]        gnt_vec;
  src_t              gnt_idx;
  logic              gnt_ok;

  assign in_data[0] = in_data_a;
  assign in_data[1] = in_data_b;
  assign in_data[2] = in_data_c;
  assign in_data[3] = in_data_d;

  assign in_ready = ~full;
  assign req      = ~empty;
  assign push     = in_valid & in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_data[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .count     (count[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  // gnt_idx is only meaningful when gnt_vec is one-hot; the legality
  // check below qualifies it before anything is popped.
  always_comb begin
    gnt_vec = {gnt_d, gnt_c, gnt_b, gnt_a};
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_vec[i]) gnt_idx = src_t'(i);
    end
    gnt_ok = is_onehot4(gnt_vec) && req[gnt_idx];
    pop    = gnt_ok ? gnt_vec : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      gnt_err   <= 1'b0;
    end else begin
      out_valid <= gnt_ok;
      gnt_err   <= (gnt_vec != 4'b0000) && !gnt_ok;
      if (gnt_ok) begin
        out_data <= head[gnt_idx];
        out_src  <= gnt_idx;
      end
    end
  end

`ifdef REQ_QUEUE4_LEVEL_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_level
    assign level[i*CW +: CW] = count[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_sticky <= 4'b0000;
    else      ovf_sticky <= ovf_sticky | (in_valid & ~in_ready);
  end
`endif

endmodule

// File: tb/tb_req_queue4.sv
// tb_req_queue4: self-checking bench for req_queue4 (DATA_W=8, DEPTH=4).
// A per-channel queue model predicts req/in_ready/gnt_err each cycle and
// pushes expected popped entries to a scoreboard, which a monitor drains
// whenever out_valid is seen.
module tb_req_queue4;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        in_valid = '0;
  logic [DATA_W-1:0] in_data_a = '0, in_data_b = '0, in_data_c = '0, in_data_d = '0;
  logic [3:0]        in_ready;
  logic [3:0]        req;
  logic              gnt_a = 1'b0, gnt_b = 1'b0, gnt_c = 1'b0, gnt_d = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              gnt_err;
`ifdef REQ_QUEUE4_LEVEL_EN
  logic [4*CW-1:0]   level;
  logic [3:0]        ovf_sticky;
  logic [3:0]        exp_ovf = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq [4][$];
  exp_t       sb [$];

  always #5 clk = ~clk;

  req_queue4 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_a (in_data_a),
    .in_data_b (in_data_b),
    .in_data_c (in_data_c),
    .in_data_d (in_data_d),
    .in_ready  (in_ready),
    .req       (req),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .gnt_c     (gnt_c),
    .gnt_d     (gnt_d),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .gnt_err   (gnt_err)
`ifdef REQ_QUEUE4_LEVEL_EN
    ,
    .level     (level),
    .ovf_sticky(ovf_sticky)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every popped entry must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_src",  32'(out_src),  32'(e.src));
      end
    end
  end

  function automatic logic [3:0] model_req();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [3:0] model_rdy();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  // One clock: drive inputs, update the model, advance to the next
  // falling edge, then check the registered outputs.
  task automatic cycle(input logic [3:0] v, input logic [7:0] da, input logic [7:0] db,
                       input logic [7:0] dc, input logic [7:0] dd, input logic [3:0] g);
    logic [7:0] d [4];
    logic [3:0] rdy_pre;
    int         ones;
    int         idx;
    logic       legal;
    d[0] = da; d[1] = db; d[2] = dc; d[3] = dd;
    rdy_pre = model_rdy();
    ones = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (g[i]) begin ones++; idx = i; end
    legal = (ones == 1) && (mq[idx].size() != 0);
    if (legal) sb.push_back('{src: 2'(idx), data: mq[idx].pop_front()});
    for (int i = 0; i < 4; i++) if (v[i] && rdy_pre[i]) mq[i].push_back(d[i]);
`ifdef REQ_QUEUE4_LEVEL_EN
    exp_ovf = exp_ovf | (v & ~rdy_pre);
`endif
    in_valid = v;
    in_data_a = da; in_data_b = db; in_data_c = dc; in_data_d = dd;
    {gnt_d, gnt_c, gnt_b, gnt_a} = g;
    @(posedge clk);
    @(negedge clk);
    chk("gnt_err",  32'(gnt_err),  32'((ones != 0) && !legal));
    chk("req",      32'(req),      32'(model_req()));
    chk("in_ready", 32'(in_ready), 32'(model_rdy()));
`ifdef REQ_QUEUE4_LEVEL_EN
    for (int i = 0; i < 4; i++)
      chk("level", 32'(level[i*CW +: CW]), 32'(mq[i].size()));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_ovf));
`endif
  endtask

  task automatic idle();
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    sb.delete();
`ifdef REQ_QUEUE4_LEVEL_EN
    exp_ovf = '0;
`endif
  endtask

  initial begin
    // Reset held with random activity on the inputs.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'($urandom);
      in_data_a = 8'($urandom); in_data_b = 8'($urandom);
      in_data_c = 8'($urandom); in_data_d = 8'($urandom);
      {gnt_d, gnt_c, gnt_b, gnt_a} = 4'($urandom);
      @(negedge clk);
      chk("rst_req",       32'(req),       32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'hF);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_gnt_err",   32'(gnt_err),   32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_out_src",   32'(out_src),   32'h0);
    end
    in_valid = '0;
    {gnt_d, gnt_c, gnt_b, gnt_a} = '0;
    rst = 1'b1;
    model_reset();
    idle();

    // First push after reset, then drain it.
    cycle(4'b0001, 8'h11, 8'h00, 8'h00, 8'h00, 4'b0000);
    chk("req_after_push", 32'(req), 32'h1);
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
    idle();

    // Ordering on channel c, then out_data holds.
    cycle(4'b0100, 8'h00, 8'h00, 8'hA1, 8'h00, 4'b0000);
    cycle(4'b0100, 8'h00, 8'h00, 8'hA2, 8'h00, 4'b0000);
    cycle(4'b0100, 8'h00, 8'h00, 8'hA3, 8'h00, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0100);
      chk("order_out_valid", 32'(out_valid), 32'h1);
    end
    chk("order_req_c", 32'(req[2]), 32'h0);
    idle();
    chk("out_hold_valid", 32'(out_valid), 32'h0);
    chk("out_hold_data",  32'(out_data),  32'hA3);
    chk("out_hold_src",   32'(out_src),   32'h2);
    chk("sb_order", 32'(sb.size()), 32'h0);

    // Full channel b: push refused while popping, space appears next cycle.
    for (int k = 0; k < 4; k++)
      cycle(4'b0010, 8'h00, 8'hB0 + 8'(k), 8'h00, 8'h00, 4'b0000);
    chk("full_rdy_b", 32'(in_ready[1]), 32'h0);
    cycle(4'b0010, 8'h00, 8'hBF, 8'h00, 8'h00, 4'b0010);
    chk("full_rdy_b_after", 32'(in_ready[1]), 32'h1);
    for (int k = 0; k < 3; k++) cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010);
    idle();
    chk("sb_full", 32'(sb.size()), 32'h0);

    // Illegal grants: multi-hot, then grant to an empty channel.
    cycle(4'b1001, 8'h1A, 8'h00, 8'h00, 8'h1D, 4'b0000);
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1001);
    chk("multi_out_valid", 32'(out_valid), 32'h0);
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010);
    chk("empty_out_valid", 32'(out_valid), 32'h0);
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000);
    // Grant in the cycle right after the last pop: req already dropped.
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000);
    // Push and illegal pop on the same empty channel: push still lands.
    cycle(4'b0100, 8'h00, 8'h00, 8'hC7, 8'h00, 4'b0100);
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0100);
    idle();
    chk("sb_illegal", 32'(sb.size()), 32'h0);

    // Wrap-around on channel d.
    for (int k = 0; k < 10; k++) begin
      cycle(4'b1000, 8'h00, 8'h00, 8'h00, 8'hD0 + 8'(k), 4'b0000);
      cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000);
    end
    idle();
    chk("sb_wrap", 32'(sb.size()), 32'h0);

    // Reset mid-stream discards queued entries.
    for (int k = 0; k < 3; k++)
      cycle(4'b0001, 8'hE0 + 8'(k), 8'h00, 8'h00, 8'h00, 4'b0000);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req",      32'(req),      32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'hF);
    chk("mid_rst_out_valid",32'(out_valid),32'h0);
    model_reset();
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    cycle(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00, 4'b0000);
    cycle(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
    chk("mid_rst_first", 32'(out_data), 32'h5A);
    idle();
    chk("sb_end", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
